// File: rtl/tlb_ptw.sv
// tlb_ptw: hardware page-table walker that fills tcache_l2.
// Accepts one TLB miss, walks Sv39 (optionally Sv48) tables with 64-bit PTE
// reads, writes the leaf into the tcache_l2 fill port, then reports done.
// One walk in flight, no PTE caching.
//
// Optional feature macro: PTW_SV48_EN (satp_mode 9 walks four levels and
// 512 GB leaves raise wr_512gB). Without it, satp_mode 9 faults in CHK.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        miss request handshake (ready only in IDLE)
//   req_vaddr, req_asid        faulting VA[VA_SZ-1:12] and its ASID
//   satp_mode, satp_ppn        translation mode (8=Sv39, 9=Sv48), root PPN
//   flush                      invalidate seen by tcache_l2 this cycle
//   mem_rd_valid/ready/addr    PTE read request channel
//   mem_rsp_valid/data/err     PTE read response channel
//   wr_entry, wr_*             one-cycle fill strobe and fill payload
//   resp_valid/fault/retry     walk completion status (one cycle)
module tlb_ptw #(
    parameter int unsigned VA_SZ = 64,
    parameter int unsigned NPHYS = 56
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [VA_SZ-13:0]    req_vaddr,
    input  logic [15:0]          req_asid,
    input  logic [3:0]           satp_mode,
    input  logic [NPHYS-13:0]    satp_ppn,
    input  logic                 flush,
    output logic                 mem_rd_valid,
    input  logic                 mem_rd_ready,
    output logic [NPHYS-1:0]     mem_rd_addr,
    input  logic                 mem_rsp_valid,
    input  logic [63:0]          mem_rsp_data,
    input  logic                 mem_rsp_err,
    output logic                 wr_entry,
    output logic [VA_SZ-13:0]    wr_vaddr,
    output logic [NPHYS-13:0]    wr_paddr,
    output logic [15:0]          wr_asid,
    output logic [6:0]           wr_gaduwrx,
    output logic                 wr_4mB,
    output logic                 wr_2mB,
    output logic                 wr_1gB,
    output logic                 wr_512gB,
    output logic                 resp_valid,
    output logic                 resp_fault,
    output logic                 resp_retry
);

    localparam int unsigned VPN_W = VA_SZ - 12;
    localparam int unsigned PPN_W = NPHYS - 12;
    localparam int unsigned LVL_W = 2;

`ifdef PTW_SV48_EN
    localparam bit SV48 = 1'b1;
`else
    localparam bit SV48 = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_RD,
        S_WAIT,
        S_FILL,
        S_FAULT,
        S_RETRY
    } state_t;

    state_t             state_q, state_d;
    logic [VPN_W-1:0]   va_q, va_d;
    logic [15:0]        asid_q, asid_d;
    logic [3:0]         mode_q, mode_d;
    logic [PPN_W-1:0]   ppn_q, ppn_d;
    logic [LVL_W-1:0]   lvl_q, lvl_d;
    logic               kill_q, kill_d;

    logic [NPHYS-1:0]   rd_addr_d;
    logic [VPN_W-1:0]   wr_vaddr_d;
    logic [PPN_W-1:0]   wr_paddr_d;
    logic [15:0]        wr_asid_d;
    logic [6:0]         wr_gaduwrx_d;
    logic               wr_2mB_d, wr_1gB_d, wr_512gB_d;

    // PTE field decode of the returning read data
    logic               pte_v, pte_r, pte_w, pte_x, pte_u, pte_g, pte_a, pte_d;
    logic [PPN_W-1:0]   pte_ppn;
    logic               unused_pte_bits;

    assign pte_v   = mem_rsp_data[0];
    assign pte_r   = mem_rsp_data[1];
    assign pte_w   = mem_rsp_data[2];
    assign pte_x   = mem_rsp_data[3];
    assign pte_u   = mem_rsp_data[4];
    assign pte_g   = mem_rsp_data[5];
    assign pte_a   = mem_rsp_data[6];
    assign pte_d   = mem_rsp_data[7];
    assign pte_ppn = mem_rsp_data[NPHYS-3:10];
    assign unused_pte_bits = ^{mem_rsp_data[63:NPHYS-2], mem_rsp_data[9:8]};

    // Canonical check: every VA bit above the top translated bit must copy it
    logic [VPN_W-27:0]  hi39;
    logic [VPN_W-36:0]  hi48;
    logic               canon_ok, mode_ok;

    assign hi39     = va_q[VPN_W-1:26];
    assign hi48     = va_q[VPN_W-1:35];
    assign mode_ok  = (mode_q == 4'd8) || (SV48 && (mode_q == 4'd9));
    assign canon_ok = (mode_q == 4'd9) ? ((&hi48) | ~(|hi48))
                                       : ((&hi39) | ~(|hi39));

    assign wr_4mB = 1'b0;

    // 9-bit VPN slice for a given level
    function automatic logic [8:0] vpn_sel(input logic [VPN_W-1:0] va,
                                           input logic [LVL_W-1:0] l);
        case (l)
            2'd0:    return va[8:0];
            2'd1:    return va[17:9];
            2'd2:    return va[26:18];
            default: return va[35:27];
        endcase
    endfunction

    // A superpage leaf must have its low PPN bits clear for its level
    function automatic logic superpage_misaligned(input logic [PPN_W-1:0] p,
                                                  input logic [LVL_W-1:0] l);
        case (l)
            2'd1:    return |p[8:0];
            2'd2:    return |p[17:0];
            2'd3:    return |p[26:0];
            default: return 1'b0;
        endcase
    endfunction

    // Next-state, datapath and next-output logic
    always_comb begin
        state_d      = state_q;
        va_d         = va_q;
        asid_d       = asid_q;
        mode_d       = mode_q;
        ppn_d        = ppn_q;
        lvl_d        = lvl_q;
        kill_d       = kill_q | (flush && (state_q != S_IDLE));
        rd_addr_d    = mem_rd_addr;
        wr_vaddr_d   = wr_vaddr;
        wr_paddr_d   = wr_paddr;
        wr_asid_d    = wr_asid;
        wr_gaduwrx_d = wr_gaduwrx;
        wr_2mB_d     = wr_2mB;
        wr_1gB_d     = wr_1gB;
`ifdef PTW_SV48_EN
        wr_512gB_d   = wr_512gB;
`else
        wr_512gB_d   = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    va_d    = req_vaddr;
                    asid_d  = req_asid;
                    mode_d  = satp_mode;
                    ppn_d   = satp_ppn;
                    lvl_d   = (SV48 && (satp_mode == 4'd9)) ? 2'd3 : 2'd2;
                    // a flush on the accept cycle already invalidates this walk
                    kill_d  = flush;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (kill_d) begin
                    state_d = S_RETRY;
                end else if (!mode_ok || !canon_ok) begin
                    state_d = S_FAULT;
                end else begin
                    rd_addr_d = {ppn_q, vpn_sel(va_q, lvl_q), 3'b000};
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                if (mem_rd_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    if (kill_d) begin
                        state_d = S_RETRY;
                    end else if (mem_rsp_err || !pte_v || (!pte_r && pte_w)) begin
                        state_d = S_FAULT;
                    end else if (!pte_r && !pte_x) begin
                        // pointer to next level
                        if (lvl_q == 2'd0) begin
                            state_d = S_FAULT;
                        end else begin
                            ppn_d     = pte_ppn;
                            lvl_d     = LVL_W'(lvl_q - 2'd1);
                            rd_addr_d = {pte_ppn, vpn_sel(va_q, lvl_d), 3'b000};
                            state_d   = S_RD;
                        end
                    end else if (!pte_a || superpage_misaligned(pte_ppn, lvl_q)) begin
                        // no hardware A/D update; misaligned superpages fault
                        state_d = S_FAULT;
                    end else begin
                        wr_vaddr_d   = va_q;
                        wr_paddr_d   = pte_ppn;
                        wr_asid_d    = asid_q;
                        wr_gaduwrx_d = {pte_g, pte_a, pte_d, pte_u, pte_w, pte_r, pte_x};
                        wr_2mB_d     = (lvl_q == 2'd1);
                        wr_1gB_d     = (lvl_q == 2'd2);
`ifdef PTW_SV48_EN
                        wr_512gB_d   = (lvl_q == 2'd3);
`endif
                        state_d      = S_FILL;
                    end
                end
            end
            S_FILL, S_FAULT, S_RETRY: begin
                kill_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                kill_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            va_q         <= '0;
            asid_q       <= '0;
            mode_q       <= '0;
            ppn_q        <= '0;
            lvl_q        <= '0;
            kill_q       <= 1'b0;
            req_ready    <= 1'b1;
            mem_rd_valid <= 1'b0;
            mem_rd_addr  <= '0;
            wr_entry     <= 1'b0;
            wr_vaddr     <= '0;
            wr_paddr     <= '0;
            wr_asid      <= '0;
            wr_gaduwrx   <= '0;
            wr_2mB       <= 1'b0;
            wr_1gB       <= 1'b0;
`ifdef PTW_SV48_EN
            wr_512gB     <= 1'b0;
`endif
            resp_valid   <= 1'b0;
            resp_fault   <= 1'b0;
            resp_retry   <= 1'b0;
        end else begin
            state_q      <= state_d;
            va_q         <= va_d;
            asid_q       <= asid_d;
            mode_q       <= mode_d;
            ppn_q        <= ppn_d;
            lvl_q        <= lvl_d;
            kill_q       <= kill_d;
            req_ready    <= (state_d == S_IDLE);
            mem_rd_valid <= (state_d == S_RD);
            mem_rd_addr  <= rd_addr_d;
            wr_entry     <= (state_d == S_FILL);
            wr_vaddr     <= wr_vaddr_d;
            wr_paddr     <= wr_paddr_d;
            wr_asid      <= wr_asid_d;
            wr_gaduwrx   <= wr_gaduwrx_d;
            wr_2mB       <= wr_2mB_d;
            wr_1gB       <= wr_1gB_d;
`ifdef PTW_SV48_EN
            wr_512gB     <= wr_512gB_d;
`endif
            resp_valid   <= (state_d == S_FILL) || (state_d == S_FAULT) ||
                            (state_d == S_RETRY);
            resp_fault   <= (state_d == S_FAULT);
            resp_retry   <= (state_d == S_RETRY);
        end
    end

`ifndef PTW_SV48_EN
    assign wr_512gB = 1'b0;
    logic unused_512;
    assign unused_512 = wr_512gB_d;
`endif

endmodule

// File: tb/tb_tlb_ptw.sv
// Scoreboard bench for tlb_ptw: directed walks over a small page-table memory.
module tb_tlb_ptw;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [51:0] req_vaddr;
    logic [15:0] req_asid;
    logic [3:0]  satp_mode;
    logic [43:0] satp_ppn;
    logic        flush;
    logic        mem_rd_valid;
    logic        mem_rd_ready;
    logic [55:0] mem_rd_addr;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        wr_entry;
    logic [51:0] wr_vaddr;
    logic [43:0] wr_paddr;
    logic [15:0] wr_asid;
    logic [6:0]  wr_gaduwrx;
    logic        wr_4mB, wr_2mB, wr_1gB, wr_512gB;
    logic        resp_valid, resp_fault, resp_retry;

    tlb_ptw dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .req_asid(req_asid), .satp_mode(satp_mode), .satp_ppn(satp_ppn),
        .flush(flush),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .wr_entry(wr_entry), .wr_vaddr(wr_vaddr), .wr_paddr(wr_paddr), .wr_asid(wr_asid),
        .wr_gaduwrx(wr_gaduwrx), .wr_4mB(wr_4mB), .wr_2mB(wr_2mB), .wr_1gB(wr_1gB),
        .wr_512gB(wr_512gB),
        .resp_valid(resp_valid), .resp_fault(resp_fault), .resp_retry(resp_retry)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic        fill;
        logic        fault;
        logic        retry;
        logic [43:0] paddr;
        logic [6:0]  perm;
        logic        s2m;
        logic        s1g;
        logic        s512;
        logic [51:0] va;
        logic [15:0] asid;
        logic [7:0]  nrd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   resp_cnt = 0;
    int   resp_base = 0;
    int   nreads = 0;
    logic [15:0] asid_ctr = 16'h0a00;

    // memory model state
    logic [63:0] pmem [logic [55:0]];
    int          rsp_lat = 0;
    int          stall_left = 0;
    logic [55:0] err_addr = '1;
    logic        rsp_pend = 1'b0;
    int          rsp_wait = 0;
    logic [55:0] pend_addr = '0;
    logic        stalled_prev = 1'b0;
    logic [55:0] hold_addr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic fill, input logic fault, input logic retry,
                                input logic [43:0] paddr, input logic [6:0] perm,
                                input logic s2m, input logic s1g, input logic s512,
                                input logic [7:0] nrd);
        exp_t e;
        e = '0;
        e.fill = fill; e.fault = fault; e.retry = retry;
        e.paddr = paddr; e.perm = perm;
        e.s2m = s2m; e.s1g = s1g; e.s512 = s512; e.nrd = nrd;
        return e;
    endfunction

    // Memory responder: read handshakes, optional stall, delayed single response
    initial begin
        mem_rd_ready  = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rsp_err   = 1'b0;
            if (stalled_prev) begin
                chk("rd_valid_hold", 64'(mem_rd_valid), 64'd1);
                chk("rd_addr_hold", 64'(mem_rd_addr), 64'(hold_addr));
            end
            stalled_prev = 1'b0;
            if (rsp_pend) begin
                if (rsp_wait > 0) begin
                    rsp_wait--;
                end else begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = pmem.exists(pend_addr) ? pmem[pend_addr] : 64'd0;
                    mem_rsp_err   = (pend_addr == err_addr);
                    rsp_pend      = 1'b0;
                end
            end
            if (mem_rd_valid) begin
                if (stall_left > 0) begin
                    mem_rd_ready = 1'b0;
                    stall_left--;
                    stalled_prev = 1'b1;
                    hold_addr    = mem_rd_addr;
                end else begin
                    mem_rd_ready = 1'b1;
                    rsp_pend     = 1'b1;
                    rsp_wait     = rsp_lat;
                    pend_addr    = mem_rd_addr;
                    nreads++;
                end
            end else begin
                mem_rd_ready = 1'b1;
            end
        end
    end

    // Monitor: pop and compare on every completion
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (wr_entry && !resp_valid) begin
                    total++; bad++;
                    $display("FAIL wr_entry_alone: got=1 exp=0");
                end
                if (resp_valid) begin
                    resp_cnt++;
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_resp: got=1 exp=0");
                    end else begin
                        e = sb.pop_front();
                        chk("resp_fault", 64'(resp_fault), 64'(e.fault));
                        chk("resp_retry", 64'(resp_retry), 64'(e.retry));
                        chk("wr_entry", 64'(wr_entry), 64'(e.fill));
                        chk("nreads", 64'(nreads), 64'(e.nrd));
                        if (e.fill) begin
                            chk("wr_paddr", 64'(wr_paddr), 64'(e.paddr));
                            chk("wr_gaduwrx", 64'(wr_gaduwrx), 64'(e.perm));
                            chk("wr_2mB", 64'(wr_2mB), 64'(e.s2m));
                            chk("wr_1gB", 64'(wr_1gB), 64'(e.s1g));
                            chk("wr_512gB", 64'(wr_512gB), 64'(e.s512));
                            chk("wr_vaddr", 64'(wr_vaddr), 64'(e.va));
                            chk("wr_asid", 64'(wr_asid), 64'(e.asid));
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input logic [51:0] va, input logic [3:0] mode,
                         input logic [43:0] root, input exp_t e_in, input logic push);
        exp_t e;
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL req_ready_timeout: got=0 exp=1");
        end
        e = e_in;
        e.va = va;
        e.asid = asid_ctr;
        req_valid = 1'b1;
        req_vaddr = va;
        req_asid  = asid_ctr;
        satp_mode = mode;
        satp_ppn  = root;
        nreads    = 0;
        resp_base = resp_cnt;
        if (push) sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        asid_ctr  = asid_ctr + 16'd1;
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (resp_cnt == resp_base && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (resp_cnt == resp_base) begin
            total++; bad++;
            $display("FAIL resp_timeout: got=none exp=resp_valid");
        end
        @(negedge clk);
    endtask

    task automatic wait_reads(input int k);
        int n;
        n = 0;
        while (nreads < k && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (nreads < k) begin
            total++; bad++;
            $display("FAIL read_timeout: got=%0d exp=%0d", nreads, k);
        end
    endtask

    localparam logic [43:0] ROOT39 = 44'h100;
    localparam logic [43:0] ROOT48 = 44'h500;
    localparam logic [51:0] VA1    = 52'h40403;   // vpn2=1 vpn1=2 vpn0=3
    localparam logic [51:0] VA2    = 52'h100A00;  // vpn2=4 vpn1=5
    localparam logic [51:0] VA3    = 52'h180E00;  // vpn2=6 vpn1=7

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_vaddr = '0; req_asid = '0;
        satp_mode = 4'd8; satp_ppn = '0; flush = 1'b0;

        pmem[56'h100008] = 64'h80001;        // L2 -> 0x200
        pmem[56'h200010] = 64'hC0001;        // L1 -> 0x300
        pmem[56'h300018] = 64'h48D14F7;      // leaf 0x12345 VRWUGAD
        pmem[56'h100020] = 64'h84001;        // L2 -> 0x210
        pmem[56'h210028] = 64'h10004B;       // 2MB leaf 0x400 VRXA
        pmem[56'h100030] = 64'h88001;        // L2 -> 0x220, L1 absent
        pmem[56'h500000] = 64'h144001;       // Sv48 chain
        pmem[56'h510000] = 64'h148001;
        pmem[56'h520000] = 64'h14C001;
        pmem[56'h530008] = 64'h2AF378F7;     // leaf 0xABCDE
        pmem[56'h500008] = 64'h20000000CF;   // 512GB leaf 0x8000000 VRWXAD

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rd_valid", 64'(mem_rd_valid), 64'd0);
        chk("rst_wr_entry", 64'(wr_entry), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("wr_4mB_tie", 64'(wr_4mB), 64'd0);

        // Sv39 4kB leaf
        issue(VA1, 4'd8, ROOT39, mk(1, 0, 0, 44'h12345, 7'b1111110, 0, 0, 0, 3), 1);
        wait_resp();
        // 2MB leaf
        issue(VA2, 4'd8, ROOT39, mk(1, 0, 0, 44'h400, 7'b0100011, 1, 0, 0, 2), 1);
        wait_resp();
        // misaligned 2MB leaf
        pmem[56'h210028] = 64'h10044B;
        issue(VA2, 4'd8, ROOT39, mk(0, 1, 0, 0, 0, 0, 0, 0, 2), 1);
        wait_resp();
        // second PTE invalid
        issue(VA3, 4'd8, ROOT39, mk(0, 1, 0, 0, 0, 0, 0, 0, 2), 1);
        wait_resp();
        // bus error on first read
        err_addr = 56'h100008;
        issue(VA1, 4'd8, ROOT39, mk(0, 1, 0, 0, 0, 0, 0, 0, 1), 1);
        wait_resp();
        err_addr = '1;
        // non-canonical, canonical-negative, bad mode
        issue(52'h8000000, 4'd8, ROOT39, mk(0, 1, 0, 0, 0, 0, 0, 0, 0), 1);
        wait_resp();
        issue(52'hFFFFFFC000000, 4'd8, ROOT39, mk(0, 1, 0, 0, 0, 0, 0, 0, 1), 1);
        wait_resp();
        issue(VA1, 4'd0, ROOT39, mk(0, 1, 0, 0, 0, 0, 0, 0, 0), 1);
        wait_resp();

        // flush while waiting on the first read
        rsp_lat = 3;
        issue(VA1, 4'd8, ROOT39, mk(0, 0, 1, 0, 0, 0, 0, 0, 1), 1);
        wait_reads(1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_resp();
        rsp_lat = 0;

        // read request stalled 5 cycles
        stall_left = 5;
        issue(VA1, 4'd8, ROOT39, mk(1, 0, 0, 44'h12345, 7'b1111110, 0, 0, 0, 3), 1);
        wait_resp();

        // reset during WAIT, late response must be ignored
        rsp_lat = 4;
        issue(VA1, 4'd8, ROOT39, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        wait_reads(1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        chk("midrst_rd_valid", 64'(mem_rd_valid), 64'd0);
        repeat (8) @(negedge clk);
        rsp_lat = 0;
        chk("stale_resp_valid", 64'(resp_valid), 64'd0);
        issue(VA1, 4'd8, ROOT39, mk(1, 0, 0, 44'h12345, 7'b1111110, 0, 0, 0, 3), 1);
        wait_resp();

`ifdef PTW_SV48_EN
        issue(52'h1, 4'd9, ROOT48, mk(1, 0, 0, 44'hABCDE, 7'b1111110, 0, 0, 0, 4), 1);
        wait_resp();
        issue(52'h8000000, 4'd9, ROOT48, mk(1, 0, 0, 44'h8000000, 7'b0110111, 0, 0, 1, 1), 1);
        wait_resp();
`else
        issue(52'h1, 4'd9, ROOT48, mk(0, 1, 0, 0, 0, 0, 0, 0, 0), 1);
        wait_resp();
        issue(52'h8000000, 4'd9, ROOT48, mk(0, 1, 0, 0, 0, 0, 0, 0, 0), 1);
        wait_resp();
`endif

        repeat (4) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
